// File: rtl/mult_pkg.sv
// Shared types and limits for the multiplier family (sequential unit and
// combinational wrapper).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mult_state_t;

    localparam int MULT_MAX_WIDTH = 16;

endpackage

// File: rtl/mult_flag_gen.sv
// Overflow/zero flags for a 2*WIDTH-bit product in unsigned or signed mode.
// Purely combinational so the combinational multiplier can reuse it.
module mult_flag_gen
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] result,
    input  logic               signed_mode,
    output logic               v,
    output logic               z
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH:0]   sign_ext;
    logic             v_u;
    logic             v_s;

    assign upper    = result[2*WIDTH-1:WIDTH];
    assign sign_ext = result[2*WIDTH-1:WIDTH-1];

    // Signed result fits only if the upper half is a pure sign extension of bit W-1.
    assign v_u = |upper;
    assign v_s = !((sign_ext == '0) || (&sign_ext));

    assign v = signed_mode ? v_s : v_u;
    assign z = (result == '0);

endmodule

// File: rtl/seq_multiplier_nbit.sv
// Multi-cycle shift-add MUL unit: one partial product per clock on operand
// magnitudes, sign applied once at the end.
module seq_multiplier_nbit
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     out,
    output logic                 V,
    output logic                 Z
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t          state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 smode;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   res;
    logic                 v_c;
    logic                 z_c;

    // Magnitudes stay unsigned in WIDTH bits, so -2^(W-1) maps to 2^(W-1) cleanly.
    assign mag_a = (signed_mode && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign mag_b = (signed_mode && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
    assign res   = neg ? ({(2*WIDTH){1'b0}} - acc) : acc;

    mult_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .result      (res),
        .signed_mode (smode),
        .v           (v_c),
        .z           (z_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            smode   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            out     <= '0;
            V       <= 1'b0;
            Z       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        smode  <= signed_mode;
                    end
                end
                RUN: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1))
                        state <= FIN;
                end
                FIN: begin
                    product <= res;
                    out     <= res[WIDTH-1:0];
                    V       <= v_c;
                    Z       <= z_c;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_nbit.sv
// Scoreboard bench for seq_multiplier_nbit at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier_nbit;

    typedef struct {
        logic [15:0] p;
        logic [7:0]  o;
        logic        v;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 1'b0, sm4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, V4, Z4;
    logic [7:0] product4;
    logic [3:0] out4;

    logic       start8 = 1'b0, sm8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, V8, Z8;
    logic [15:0] product8;
    logic [7:0] out8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bc4 = 0, bc8 = 0;
    exp_t q4[$];
    exp_t q8[$];

    seq_multiplier_nbit #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4),
        .out(out4), .V(V4), .Z(Z4)
    );

    seq_multiplier_nbit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8),
        .out(out8), .V(V8), .Z(Z8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Caller is at a negedge; start is held for exactly one rising edge.
    task automatic go4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] p, input logic [3:0] o, input logic v,
                       input logic z, input bit push);
        exp_t e;
        start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
        if (push) begin
            e.p = {8'h00, p}; e.o = {4'h0, o}; e.v = v; e.z = z; e.cyc = cyc + 6;
            q4.push_back(e);
        end
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic go8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input logic [7:0] o, input logic v,
                       input logic z);
        exp_t e;
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        e.p = p; e.o = o; e.v = v; e.z = z; e.cyc = cyc + 10;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 60; i++) begin
            if ((which == 4 ? q4.size() : q8.size()) == 0) break;
            @(negedge clk);
        end
        chk(which == 4 ? "drain4" : "drain8", which == 4 ? q4.size() : q8.size(), 0);
    endtask

    initial begin : mon4
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) bc4 = 0;
            else begin
                if (busy4) bc4++;
                if (done4) begin
                    if (q4.size() == 0) chk("unexpected_done4", 32'(done4), 0);
                    else begin
                        e = q4.pop_front();
                        chk("product4", 32'(product4), 32'(e.p));
                        chk("out4", 32'(out4), 32'(e.o));
                        chk("V4", 32'(V4), 32'(e.v));
                        chk("Z4", 32'(Z4), 32'(e.z));
                        chk("latency4", 32'(cyc), 32'(e.cyc));
                        chk("busy_cycles4", 32'(bc4), 5);
                        bc4 = 0;
                    end
                end
            end
        end
    end

    initial begin : mon8
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) bc8 = 0;
            else begin
                if (busy8) bc8++;
                if (done8) begin
                    if (q8.size() == 0) chk("unexpected_done8", 32'(done8), 0);
                    else begin
                        e = q8.pop_front();
                        chk("product8", 32'(product8), 32'(e.p));
                        chk("out8", 32'(out8), 32'(e.o));
                        chk("V8", 32'(V8), 32'(e.v));
                        chk("Z8", 32'(Z8), 32'(e.z));
                        chk("latency8", 32'(cyc), 32'(e.cyc));
                        chk("busy_cycles8", 32'(bc8), 9);
                        bc8 = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_product", 32'(product4), 0);
        chk("rst_out", 32'(out4), 0);
        chk("rst_VZ", 32'({V4, Z4}), 0);
        chk("rst_product8", 32'(product8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned directed vectors
        go4(0, 4'd3, 4'd5, 8'h0F, 4'hF, 0, 0, 1); drain(4);
        @(negedge clk); go4(0, 4'd7, 4'd3, 8'h15, 4'h5, 1, 0, 1); drain(4);
        @(negedge clk); go4(0, 4'd0, 4'd9, 8'h00, 4'h0, 0, 1, 1); drain(4);
        @(negedge clk); go4(0, 4'hF, 4'hF, 8'hE1, 4'h1, 1, 0, 1); drain(4);

        // Signed directed vectors
        @(negedge clk); go4(1, 4'hD, 4'h2, 8'hFA, 4'hA, 0, 0, 1); drain(4);
        @(negedge clk); go4(1, 4'h8, 4'h8, 8'h40, 4'h0, 1, 0, 1); drain(4);
        @(negedge clk); go4(1, 4'h5, 4'hF, 8'hFB, 4'hB, 0, 0, 1); drain(4);
        @(negedge clk); go4(1, 4'h7, 4'h7, 8'h31, 4'h1, 1, 0, 1); drain(4);

        // Start during RUN ignored, then back-to-back start in the done cycle
        @(negedge clk); go4(0, 4'd3, 4'd5, 8'h0F, 4'hF, 0, 0, 1);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("done_seen4", 32'(hit), 1);
        go4(0, 4'd2, 4'd6, 8'h0C, 4'hC, 0, 0, 1);
        drain(4);

        // Asynchronous reset in the 3rd RUN cycle aborts without done
        @(negedge clk); go4(0, 4'd3, 4'd5, 8'h00, 4'h0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 0);
        chk("abort_product", 32'(product4), 0);
        chk("abort_out", 32'(out4), 0);
        chk("abort_VZ", 32'({V4, Z4}), 0);
        chk("abort_done", 32'(done4), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", 32'(done4), 0);
        go4(0, 4'd4, 4'd4, 8'h10, 4'h0, 1, 0, 1); drain(4);

        // WIDTH=8 boundaries
        @(negedge clk); go8(0, 8'hFF, 8'hFF, 16'hFE01, 8'h01, 1, 0); drain(8);
        @(negedge clk); go8(1, 8'h80, 8'h01, 16'hFF80, 8'h80, 0, 0); drain(8);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
